// File: rtl/scratch_bank_pkg.sv
// scratch_bank_pkg: ZX-Uno register-map constants and helpers shared by the scratch bank.
package scratch_bank_pkg;

  localparam logic [7:0] ZXUNO_SCRATCH_ADDR = 8'hFD;
  localparam logic [7:0] ZXUNO_SCRATCH_DATA = 8'hFE;

  typedef struct packed {
    logic hit_addr;
    logic hit_data;
    logic rd;
    logic wr;
  } bus_dec_t;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/scratch_bank_ram.sv
// scratch_bank_ram: DEPTH x 8 storage, synchronous write, asynchronous read, never reset.
module scratch_bank_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we_i) mem[addr_i] <= wdata_i;

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/scratch_bank.sv
// scratch_bank: pointer/data register pair giving bus access to a small scratch RAM,
// with optional pointer post-increment at the end of each data-window access.
module scratch_bank
  import scratch_bank_pkg::*;
#(
  parameter logic [7:0] ADDR_REG = ZXUNO_SCRATCH_ADDR,
  parameter logic [7:0] DATA_REG = ZXUNO_SCRATCH_DATA,
  parameter int         DEPTH    = 16,
  parameter bit         AUTOINC  = 1'b1
) (
  input  logic       clk,
  input  logic       poweron_rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n
);

  localparam int PW = ptr_width(DEPTH);

  bus_dec_t      bus;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          acc_q, acc_d;
  logic          run_q;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    rdata;
  logic          acc_end, ptr_ld, we;

  assign bus = '{hit_addr: zxuno_addr == ADDR_REG, hit_data: zxuno_addr == DATA_REG,
                 rd: zxuno_regrd, wr: zxuno_regwr};

  // run_q keeps the RAM write enable low while reset is held, so an aborted access stores nothing
  always_comb begin
    acc_d   = bus.hit_data && (bus.rd || bus.wr);
    acc_end = acc_q && !acc_d;
    ptr_ld  = bus.wr && bus.hit_addr;
    we      = run_q && bus.wr && bus.hit_data;
    ptr_d   = ptr_ld ? din[PW-1:0] : (AUTOINC && acc_end) ? ptr_q + 1'b1 : ptr_q;
    dout_d  = bus.hit_addr ? 8'(ptr_q) : rdata;
  end

  always_ff @(posedge clk or negedge poweron_rst_n)
    if (!poweron_rst_n) begin
      ptr_q  <= '0;
      acc_q  <= 1'b0;
      run_q  <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      ptr_q  <= ptr_d;
      acc_q  <= acc_d;
      run_q  <= 1'b1;
      dout_q <= dout_d;
    end

  scratch_bank_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (ptr_q),
    .wdata_i (din),
    .rdata_o (rdata)
  );

  assign dout = dout_q;
  assign oe_n = !(bus.rd && (bus.hit_addr || bus.hit_data));

endmodule

// File: doc/scratch_bank.md
SCRATCH_BANK -- requirements
Module: scratch_bank

Interface
REQ-001 Parameter ADDR_REG, default 8'hFD, ZX-Uno register number of the pointer register.
REQ-002 Parameter DATA_REG, default 8'hFE, ZX-Uno register number of the data window.
REQ-003 Parameter DEPTH, default 16, entry count; power of two, 2..256; pointer width PW = log2(DEPTH).
REQ-004 Parameter AUTOINC, default 1, 1 = pointer post-increments after each data access, 0 = pointer static.
REQ-005 Port clk  input  1  single system clock; all state on rising edge.
REQ-006 Port poweron_rst_n  input  1  asynchronous active-low reset.
REQ-007 Port zxuno_addr  input  8  currently selected ZX-Uno register number.
REQ-008 Port zxuno_regrd  input  1  read strobe for the selected register; may stay high several cycles.
REQ-009 Port zxuno_regwr  input  1  write strobe for the selected register; may stay high several cycles.
REQ-010 Port din  input  8  write data.
REQ-011 Port dout  output  8  registered read data.
REQ-012 Port oe_n  output  1  active-low read-data enable toward the bus mux.

Function
REQ-013 oe_n SHALL be low combinationally iff zxuno_regrd=1 and zxuno_addr equals ADDR_REG or DATA_REG.
REQ-014 Pointer ptr (PW bits): zxuno_regwr=1 with addr=ADDR_REG SHALL load ptr <= din[PW-1:0]; upper din bits ignored.
REQ-015 dout SHALL update every cycle, one-cycle latency: {zeros, ptr} when addr=ADDR_REG, else mem[ptr].
REQ-016 zxuno_regwr=1 with addr=DATA_REG SHALL write mem[ptr] <= din each cycle the strobe is high; pointer unchanged while strobe high.
REQ-017 Data access flag acc_q SHALL register (addr=DATA_REG and (zxuno_regrd or zxuno_regwr)) each cycle.
REQ-018 Access end = acc_q=1 and current access term 0; with AUTOINC=1, ptr SHALL increment by 1 on that cycle.
REQ-019 Increment SHALL wrap modulo DEPTH: ptr DEPTH-1 -> 0.
REQ-020 With AUTOINC=0, data accesses SHALL never change ptr.
REQ-021 Access end coinciding with an ADDR_REG write (address changed with strobe held): the ADDR_REG load SHALL win, no increment.
REQ-022 Strobes for any other register number SHALL change no state; dout then shows mem[ptr], oe_n high.
REQ-023 Read and write strobes both high on DATA_REG SHALL perform the write; a single increment at access end.

Reset
REQ-024 poweron_rst_n=0 SHALL asynchronously force ptr=0, acc_q=0, dout=8'h00; oe_n follows REQ-013 combinationally.
REQ-025 Storage array SHALL NOT be reset (distributed RAM inference); contents 8'h00 at configuration, preserved across poweron_rst_n.
REQ-026 Reset asserted mid-access SHALL abort it: no increment at release, no write while low.

Structure
REQ-027 Default ADDR_REG/DATA_REG register numbers SHALL live in the shared ZX-Uno register-map constants file, not as literals here.
REQ-028 Storage SHALL be sub-module scratch_bank_ram: DEPTH x 8, synchronous write, asynchronous read, no reset.
REQ-029 Pointer, access-end detect and output register SHALL be in scratch_bank; no other sub-modules.

Verification
REQ-030 Reset, write 8'h05 to ADDR_REG, read ADDR_REG -> dout=8'h05 one cycle after strobe, oe_n low during strobe.
REQ-031 AUTOINC=1, DEPTH=16: ptr=14, write 8'hAA, 8'hBB, 8'hCC to DATA_REG -> mem[14]=AA, mem[15]=BB, mem[0]=CC, ptr=1.
REQ-032 Write strobe on DATA_REG held 5 cycles with din=8'h3C -> one entry written, ptr advances exactly once.
REQ-033 AUTOINC=0: ptr=3, three DATA_REG reads -> all return mem[3], ptr stays 3.
REQ-034 Assert poweron_rst_n low mid-write to DATA_REG, ptr=7 -> ptr=0, dout=0, no increment after release, other entries intact.
REQ-035 Strobe on register 8'h40 with din=8'hFF -> ptr and storage unchanged, oe_n high.
